// File: rtl/craft_mix_columns.sv
// CRAFT MixColumns on a serial nibble stream: a 4-stage nibble buffer that shifts
// columns in/out one nibble per cycle and applies the involutory CRAFT matrix in place.
module craft_mix_columns (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    input  logic       CM0,
    input  logic       CM1,
    output logic [3:0] out
);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_SHIFT,
        OP_MIX
    } op_e;

    // Stage 0 is the output head, stage 3 the input tail.
    logic [3:0][3:0] r_q;
    logic [3:0][3:0] r_d;
    op_e             op;

    always_comb begin
        if (!CM0) begin
            op = OP_MIX;
        end else if (CM1) begin
            op = OP_SHIFT;
        end else begin
            op = OP_HOLD;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path drives r_d and no latch is inferred.
        r_d = r_q;
        case (op)
            OP_SHIFT: begin
                r_d[0] = r_q[1];
                r_d[1] = r_q[2];
                r_d[2] = r_q[3];
                r_d[3] = in;
            end
            OP_MIX: begin
                r_d[0] = r_q[0] ^ r_q[2] ^ r_q[3];
                r_d[1] = r_q[1] ^ r_q[3];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the buffer is small state, not a RAM, so it is reset to flush any partial column.
        if (rst) begin
            r_q <= '0;
        end else begin
            // NOTE: non-blocking so all stages update from pre-edge values simultaneously.
            r_q <= r_d;
        end
    end

    assign out = r_q[0];

endmodule

// File: tb/tb_craft_mix_columns.sv
// Scoreboard bench for craft_mix_columns: stimulus queues hand-computed expected
// nibbles tagged with the cycle they belong to; a monitor pops and compares.
module tb_craft_mix_columns;

    logic       clk;
    logic       rst;
    logic [3:0] in;
    logic       CM0;
    logic       CM1;
    logic [3:0] out;

    typedef struct {
        int         cyc;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    craft_mix_columns dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .CM0 (CM0),
        .CM1 (CM1),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v,
                         input bit on_time);
        checks++;
        if (!on_time || act !== exp_v) begin
            errors++;
            $display("FAIL %s: out=%b required=%b on_time=%0b (cycle %0d)",
                     name, act, exp_v, on_time, cyc);
        end
    endtask

    // One clock edge with the given controls; returns #1 after the edge.
    task automatic edge_op(input logic r, input logic c0, input logic c1, input logic [3:0] d);
        @(negedge clk);
        rst = r;
        CM0 = c0;
        CM1 = c1;
        in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        edge_op(1'b1, 1'b1, 1'b1, 4'hf);
    endtask

    task automatic shift(input logic [3:0] d);
        edge_op(1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic mix();
        edge_op(1'b0, 1'b0, 1'b1, 4'hf);
    endtask

    // Monitor: compares every queued expectation belonging to the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check(e.name, out, e.val, e.cyc == cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        CM0 = 1'b1;
        CM1 = 1'b1;
        in  = 4'h0;

        // Reset with mix strobe and data present: reset wins.
        edge_op(1'b1, 1'b0, 1'b1, 4'hf);
        expect_out("reset_state", 4'h0);

        // Basic column 1,2,4,8.
        shift(4'h1); shift(4'h2); shift(4'h4); shift(4'h8);
        expect_out("load_a0", 4'h1);
        mix();
        expect_out("basic_a0", 4'hd);
        shift(4'h0); expect_out("basic_a1", 4'ha);
        shift(4'h0); expect_out("basic_a2", 4'h4);
        shift(4'h0); expect_out("basic_a3", 4'h8);

        // All-ones column.
        do_reset();
        shift(4'h1); shift(4'h1); shift(4'h1); shift(4'h1);
        mix();
        expect_out("ones_a0", 4'h1);
        shift(4'h0); expect_out("ones_a1", 4'h0);
        shift(4'h0); expect_out("ones_a2", 4'h1);
        shift(4'h0); expect_out("ones_a3", 4'h1);

        // Double mix restores the column; second strobe has CM1=0.
        do_reset();
        shift(4'h3); shift(4'h5); shift(4'h9); shift(4'h6);
        mix();
        expect_out("inv_first", 4'hc);
        edge_op(1'b0, 1'b0, 1'b0, 4'hf);
        expect_out("inv_a0", 4'h3);
        shift(4'h0); expect_out("inv_a1", 4'h5);
        shift(4'h0); expect_out("inv_a2", 4'h9);
        shift(4'h0); expect_out("inv_a3", 4'h6);

        // Hold ignores input, then shifting resumes unchanged.
        do_reset();
        shift(4'h7); shift(4'hb); shift(4'h2); shift(4'he);
        for (int i = 0; i < 3; i++) begin
            edge_op(1'b0, 1'b1, 1'b0, 4'hf);
            expect_out("hold", 4'h7);
        end
        shift(4'h0); expect_out("resume_1", 4'hb);
        shift(4'h0); expect_out("resume_2", 4'h2);
        shift(4'h0); expect_out("resume_3", 4'he);
        shift(4'h0); expect_out("resume_4", 4'h0);

        // Reset mid-column discards data; a following mix yields zeros.
        do_reset();
        shift(4'h7); shift(4'hb); shift(4'h2); shift(4'he);
        do_reset();
        expect_out("midrst", 4'h0);
        mix();
        expect_out("midrst_mix0", 4'h0);
        for (int i = 0; i < 3; i++) begin
            shift(4'h0);
            expect_out("midrst_shift", 4'h0);
        end

        // Mix before the buffer is full operates on reset zeros.
        do_reset();
        shift(4'h1); shift(4'h2);
        mix();
        expect_out("partial_a0", 4'h3);
        shift(4'h0); expect_out("partial_a1", 4'h2);
        shift(4'h0); expect_out("partial_a2", 4'h1);
        shift(4'h0); expect_out("partial_a3", 4'h2);

        // Back-to-back: shift out mixed A while shifting in B = 5,6,7,9.
        do_reset();
        shift(4'h1); shift(4'h2); shift(4'h4); shift(4'h8);
        mix();
        expect_out("b2b_a0", 4'hd);
        shift(4'h5); expect_out("b2b_a1", 4'ha);
        shift(4'h6); expect_out("b2b_a2", 4'h4);
        shift(4'h7); expect_out("b2b_a3", 4'h8);
        shift(4'h9); expect_out("b2b_b0_raw", 4'h5);
        mix();
        expect_out("b2b_b0", 4'hb);
        shift(4'h0); expect_out("b2b_b1", 4'hf);
        shift(4'h0); expect_out("b2b_b2", 4'h7);
        shift(4'h0); expect_out("b2b_b3", 4'h9);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never compared, required=%b", e.name, e.val);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/craft_mix_columns.md
CRAFT_MIX_COLUMNS -- requirements
Module: craft_mix_columns

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clocks or asynchronous controls.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in  input  4  serial nibble input, shifted into the column buffer.
REQ-005 CM0  input  1  active-low mix strobe; 0 = load MixColumns result in parallel this edge.
REQ-006 CM1  input  1  active-high shift enable; 1 = shift when CM0=1, 0 = hold.
REQ-007 out  output  4  serial nibble output, driven directly from buffer stage r0 (registered, no combinational path from inputs).

Function
REQ-008 The block SHALL hold a 4-stage, 4-bit-wide buffer r0..r3 (r0 = output head, r3 = input tail).
REQ-009 Edge priority SHALL be: rst, then CM0=0 (mix), then CM1=1 (shift), else hold.
REQ-010 Shift (CM0=1, CM1=1): r0<=r1, r1<=r2, r2<=r3, r3<=in.
REQ-011 Hold (CM0=1, CM1=0): all stages keep their value; in is ignored.
REQ-012 Mix (CM0=0, any CM1): r0<=r0^r2^r3, r1<=r1^r3, r2<=r2, r3<=r3 (CRAFT matrix rows 1011/0101/0010/0001 over GF(2) per bit); in is ignored on that edge.
REQ-013 Column order: first nibble shifted in is column element a0, fourth is a3; after four shifts r0..r3 = a0..a3.
REQ-014 Mixed results SHALL appear on out starting the cycle after the mix edge, in order a0', a1', a2', a3', one per subsequent shift edge.
REQ-015 Shifting out the mixed column and shifting in the next column SHALL overlap: each shift edge emits one result nibble and accepts one new input nibble (full throughput, one nibble per cycle; latency 4 shift cycles plus 1 mix cycle per column).
REQ-016 All operations SHALL be purely bitwise XOR; no carries, widths fixed at 4 bits per stage.
REQ-017 Consecutive mix strobes (CM0=0 on back-to-back edges) SHALL each apply the matrix to the current buffer contents (matrix is an involution, so two mixes restore the original).
REQ-018 Before the buffer has been filled with four inputs after reset, shift/mix SHALL operate on the reset zeros; no error indication.

Reset
REQ-019 On a rising edge with rst=1, r0..r3 SHALL all become 4'b0000, so out=0 the following cycle; CM0, CM1 and in are ignored on that edge.
REQ-020 Reset asserted mid-column (during shift-in or shift-out) SHALL discard all buffered data; no partial result is retained.
REQ-021 After rst deasserts, the first shift edge SHALL accept in into r3 normally.

Verification
REQ-022 Reset, CM1=1, CM0=1; shift in 0001,0010,0100,1000; one edge with CM0=0; then CM0=1 -> out = 1101, 1010, 0100, 1000 on the next four cycles.
REQ-023 Shift in 0001,0001,0001,0001; mix -> out = 0001(1^1^1), 0000, 0001, 0001.
REQ-024 After loading a column, apply CM0=0 on two consecutive edges -> out sequence equals the original input column (involution check).
REQ-025 Load column, set CM1=0 for 3 cycles with CM0=1 -> out stays constant at r0; resume CM1=1 -> sequence continues unchanged.
REQ-026 Load column, assert rst for one edge -> out = 0000; a following mix with no new input -> out remains 0000 for four shift cycles.
REQ-027 Back-to-back columns: while shifting out mixed column A, shift in column B; mix B -> both result sequences match REQ-012 with no bubble cycle.
